// File: rtl/channel_demux_pkg.sv
// Shared definitions for the channel demux: selector extract, drop counter width,
// and the queue occupancy type.
package ChannelPkg;

  localparam int DropCountW = 16;
  localparam int MaxW       = 256;
  localparam int QueueDepth = 2;

  typedef logic [$clog2(QueueDepth+1)-1:0] queue_count_t;

  // Pull a w-bit field starting at lsb out of a word zero-extended to MaxW bits.
  function automatic logic [31:0] sel_field(input logic [MaxW-1:0] d, input int lsb, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < w) ? d[lsb + i] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/channel_demux_queue.sv
// One push/pop queue of D entries with registered storage; all D entries usable.
module channel_demux_queue
  import ChannelPkg::*;
#(
  parameter int N = 32,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [N-1:0] wdata,
  input  logic         pop,
  output logic [N-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int LogD = $clog2(D);
  localparam int CntW = $clog2(D + 1);

  logic [N-1:0]    mem_r [D];
  logic [LogD-1:0] head_r;
  logic [LogD-1:0] tail_r;
  logic [CntW-1:0] count_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  always_comb begin
    full      = (count_r == CntW'(D));
    empty     = (count_r == {CntW{1'b0}});
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    rdata     = mem_r[head_r];
  end

  // Storage carries no reset; validity comes from count_r alone.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[tail_r] <= wdata;
    end
  end

  // Pointers wrap naturally since D is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {LogD{1'b0}};
      tail_r  <= {LogD{1'b0}};
      count_r <= {CntW{1'b0}};
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + LogD'(1);
      end
      if (pop_ok_s) begin
        head_r <= head_r + LogD'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/channel_demux.sv
// Registered 1:M channel router with per-output queues and a saturating drop counter.
// Optional build macro CHANNEL_DEMUX_STRIP_EN zeroes the selector field in stored words.
module channel_demux
  import ChannelPkg::*;
#(
  parameter int N      = 32,
  parameter int M      = 4,
  parameter int SelLSB = N - $clog2(M),
  parameter int D      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            in_d,
  input  logic                    in_v,
  output logic                    in_a,
  output logic [M-1:0][N-1:0]     out_d,
  output logic [M-1:0]            out_v,
  input  logic [M-1:0]            out_a,
  output logic [DropCountW-1:0]   drop_count
);

  localparam int LogM = (M < 2) ? 1 : $clog2(M);

  if (M < 2) begin : g_bad_m
    $error("channel_demux: M must be at least 2");
  end
  if ((D < 2) || ((D & (D - 1)) != 0)) begin : g_bad_d
    $error("channel_demux: D must be a power of 2 and at least 2");
  end

  logic [LogM-1:0]       sel_s;
  logic                  in_range_s;
  logic                  sel_full_s;
  logic [M-1:0]          full_s;
  logic [M-1:0]          empty_s;
  logic [M-1:0]          push_s;
  logic [N-1:0]          wdata_s;
  logic [DropCountW-1:0] drop_cnt_r;

  // Ack never looks at out_a: a full queue refuses even when it pops this cycle.
  always_comb begin
    sel_s      = LogM'(sel_field(MaxW'(in_d), SelLSB, LogM));
    in_range_s = ({1'b0, sel_s} < (LogM + 1)'(M));
    sel_full_s = 1'b0;
    for (int k = 0; k < M; k++) begin
      sel_full_s = sel_full_s | ((sel_s == LogM'(k)) & full_s[k]);
    end
    if (reset) begin
      in_a = 1'b0;
    end else if (!in_v) begin
      in_a = 1'b0;
    end else if (in_range_s) begin
      in_a = ~sel_full_s;
    end else begin
      in_a = 1'b1;
    end
    for (int k = 0; k < M; k++) begin
      push_s[k] = in_a & in_range_s & (sel_s == LogM'(k));
    end
  end

  always_comb begin
    wdata_s = in_d;
`ifdef CHANNEL_DEMUX_STRIP_EN
    wdata_s[SelLSB +: LogM] = {LogM{1'b0}};
`else
    wdata_s[SelLSB +: LogM] = in_d[SelLSB +: LogM];
`endif
  end

  // Out-of-range words are acked and counted, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= {DropCountW{1'b0}};
    end else if (in_a && !in_range_s && !(&drop_cnt_r)) begin
      drop_cnt_r <= drop_cnt_r + DropCountW'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_count = drop_cnt_r;

  for (genvar k = 0; k < M; k++) begin : g_queue
    channel_demux_queue #(.N(N), .D(D)) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (push_s[k]),
      .wdata (wdata_s),
      .pop   (out_a[k]),
      .rdata (out_d[k]),
      .full  (full_s[k]),
      .empty (empty_s[k])
    );
    assign out_v[k] = ~empty_s[k];
  end

endmodule

// File: tb/tb_channel_demux.sv
// Directed bench for channel_demux: an M=4 instance for routing/backpressure/reset/strip
// and an M=3 instance for the out-of-range drop counter.
module tb_channel_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [31:0]          in_d;
  logic                 in_v;
  logic                 in_a;
  logic [3:0][31:0]     out_d;
  logic [3:0]           out_v;
  logic [3:0]           out_a;
  logic [15:0]          drop_count;

  logic [31:0]          in3_d;
  logic                 in3_v;
  logic                 in3_a;
  logic [2:0][31:0]     out3_d;
  logic [2:0]           out3_v;
  logic [2:0]           out3_a;
  logic [15:0]          drop3_count;

  int n_vec = 0;
  int n_err = 0;

  channel_demux #(.N(32), .M(4), .D(2)) u_dut4 (
    .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
    .out_d(out_d), .out_v(out_v), .out_a(out_a), .drop_count(drop_count)
  );

  channel_demux #(.N(32), .M(3), .D(2)) u_dut3 (
    .clk(clk), .reset(reset), .in_d(in3_d), .in_v(in3_v), .in_a(in3_a),
    .out_d(out3_d), .out_v(out3_v), .out_a(out3_a), .drop_count(drop3_count)
  );

  // Expected stored word: selector bits [31:30] cleared only in the strip build.
  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef CHANNEL_DEMUX_STRIP_EN
    return {2'b00, w[29:0]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] word(input int sel, input logic [29:0] payload);
    logic [1:0] s;
    s = 2'(sel);
    return {s, payload};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_v  = 1'b1;
    in_d  = word(0, 30'h55);
    out_a = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (in_a !== 1'b0 || out_v !== 4'b0000 || drop_count !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_hold: in_a=%b out_v=%b drop=%h expected 0/0000/0000", in_a, out_v, drop_count);
      end
    end
    reset = 1'b0;
    #1;
    chk1("reset_release_ack", in_a, 1'b1);
    step();
    in_v = 1'b0;
    n_vec++;
    if (out_v !== 4'b0001 || out_d[0] !== stored(word(0, 30'h55))) begin
      n_err++;
      $display("FAIL reset_first_word: out_v=%b d0=%h expected 0001/%h", out_v, out_d[0], stored(word(0, 30'h55)));
    end
    out_a = 4'b1111;
    step();
    n_vec++;
    if (out_v !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_drain: out_v=%b expected 0000", out_v);
    end
  endtask

  task automatic test_routing();
    logic [31:0] w;
    out_a = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      w    = word(k, 30'hA0 + 30'(k));
      in_d = w;
      in_v = 1'b1;
      #1;
      chk1("route_ack", in_a, 1'b1);
      step();
      n_vec++;
      if (out_v !== (4'b0001 << k) || out_d[k] !== stored(w)) begin
        n_err++;
        $display("FAIL route_out%0d: out_v=%b d=%h expected %b/%h", k, out_v, out_d[k], 4'b0001 << k, stored(w));
      end
    end
    in_v = 1'b0;
    step();
    n_vec++;
    if (out_v !== 4'b0000) begin
      n_err++;
      $display("FAIL route_idle: out_v=%b expected 0000", out_v);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w1, w2, w3, w0;
    w1 = word(2, 30'h111);
    w2 = word(2, 30'h222);
    w3 = word(2, 30'h333);
    w0 = word(0, 30'h0F0);
    out_a = 4'b1011;
    in_v = 1'b1; in_d = w1; #1;
    chk1("bp_ack_w1", in_a, 1'b1);
    step();
    in_d = w2; #1;
    chk1("bp_ack_w2", in_a, 1'b1);
    step();
    in_d = w3; #1;
    chk1("bp_stall_w3", in_a, 1'b0);
    n_vec++;
    if (out_v !== 4'b0100 || out_d[2] !== stored(w1)) begin
      n_err++;
      $display("FAIL bp_head: out_v=%b d2=%h expected 0100/%h", out_v, out_d[2], stored(w1));
    end
    step();
    chk1("bp_still_stalled", in_a, 1'b0);
    chk1("bp_out0_blocked", out_v[0], 1'b0);
    out_a = 4'b1111; #1;
    chk1("bp_ack_ignores_out_a", in_a, 1'b0);
    step();
    chk1("bp_resume_ack", in_a, 1'b1);
    n_vec++;
    if (out_d[2] !== stored(w2)) begin
      n_err++;
      $display("FAIL bp_order_w2: d2=%h expected %h", out_d[2], stored(w2));
    end
    step();
    n_vec++;
    if (out_v !== 4'b0100 || out_d[2] !== stored(w3)) begin
      n_err++;
      $display("FAIL bp_order_w3: out_v=%b d2=%h expected 0100/%h", out_v, out_d[2], stored(w3));
    end
    in_d = w0; #1;
    chk1("bp_ack_w0", in_a, 1'b1);
    step();
    in_v = 1'b0;
    n_vec++;
    if (out_v !== 4'b0001 || out_d[0] !== stored(w0)) begin
      n_err++;
      $display("FAIL bp_w0: out_v=%b d0=%h expected 0001/%h", out_v, out_d[0], stored(w0));
    end
    step();
  endtask

  task automatic test_drop();
    out3_a = 3'b111;
    in3_v  = 1'b1;
    in3_d  = word(3, 30'h5);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("drop_ack", in3_a, 1'b1);
      step();
      chk1("drop_no_valid", |out3_v, 1'b0);
    end
    in3_v = 1'b0;
    n_vec++;
    if (drop3_count !== 16'd5) begin
      n_err++;
      $display("FAIL drop_count5: got %h expected 0005", drop3_count);
    end
    force u_dut3.drop_cnt_r = 16'hFFFE;
    #1;
    release u_dut3.drop_cnt_r;
    in3_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (drop3_count !== 16'hFFFF) begin
        n_err++;
        $display("FAIL drop_saturate: got %h expected ffff", drop3_count);
      end
    end
    in3_v = 1'b0;
    n_vec++;
    if (drop_count !== 16'h0000) begin
      n_err++;
      $display("FAIL drop_in_range_dut: got %h expected 0000", drop_count);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] wn;
    wn = word(1, 30'h777);
    out_a = 4'b1101;
    in_v = 1'b1;
    in_d = word(1, 30'h601); step();
    in_d = word(1, 30'h602); step();
    #1;
    chk1("mr_full_refuses", in_a, 1'b0);
    n_vec++;
    if (out_v !== 4'b0010) begin
      n_err++;
      $display("FAIL mr_filled: out_v=%b expected 0010", out_v);
    end
    reset = 1'b1; #1;
    chk1("mr_ack_in_reset", in_a, 1'b0);
    step();
    reset = 1'b0;
    in_v  = 1'b0;
    n_vec++;
    if (out_v !== 4'b0000 || drop3_count !== 16'h0000) begin
      n_err++;
      $display("FAIL mr_cleared: out_v=%b drop3=%h expected 0000/0000", out_v, drop3_count);
    end
    in_v = 1'b1; in_d = wn;
    step();
    in_v = 1'b0;
    n_vec++;
    if (out_v !== 4'b0010 || out_d[1] !== stored(wn)) begin
      n_err++;
      $display("FAIL mr_new_word: out_v=%b d1=%h expected 0010/%h", out_v, out_d[1], stored(wn));
    end
    out_a = 4'b1111;
    step();
    n_vec++;
    if (out_v !== 4'b0000) begin
      n_err++;
      $display("FAIL mr_alone: out_v=%b expected 0000", out_v);
    end
  endtask

  task automatic test_strip();
    logic [31:0] exp_d;
`ifdef CHANNEL_DEMUX_STRIP_EN
    exp_d = 32'h0000_1234;
`else
    exp_d = 32'hC000_1234;
`endif
    out_a = 4'b1111;
    in_v  = 1'b1;
    in_d  = 32'hC000_1234;
    step();
    in_v = 1'b0;
    n_vec++;
    if (out_v !== 4'b1000 || out_d[3] !== exp_d) begin
      n_err++;
      $display("FAIL strip: out_v=%b d3=%h expected 1000/%h", out_v, out_d[3], exp_d);
    end
    step();
  endtask

  initial begin
    reset  = 1'b1;
    in_v   = 1'b0;
    in_d   = 32'h0;
    out_a  = 4'b0000;
    in3_v  = 1'b0;
    in3_d  = 32'h0;
    out3_a = 3'b000;
    @(negedge clk);
    test_reset();
    test_routing();
    test_backpressure();
    test_drop();
    test_mid_reset();
    test_strip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
